// File: rtl/cmv300_stream_emulator.sv
// -----------------------------------------------------------------------------
// cmv300_stream_emulator
//
// Stands in for the CMV300 image sensor's 8-bit parallel pixel output. On a
// rising edge of CVM300_FRAME_REQ it waits FRAME_DELAY cycles. It then emits
// V_LINES lines of H_PIXELS valid pixels each, with LINE_GAP blanking cycles
// between lines. Pixel values follow a deterministic test pattern, so a
// captured frame can be checked bit-exactly.
//
// Ports
//   CVM300_CLK_IN      in   1       the only clock, rising edge
//   CVM300_SYS_RES_N   in   1       asynchronous active-low reset
//   CVM300_FRAME_REQ   in   1       frame request level, 0->1 starts a frame
//   pattern_sel        in   2       0 column ramp, 1 row ramp, 2 diagonal,
//                                   3 checker (latched when a frame starts)
//   CVM300_Line_valid  out  1       high during active pixels of a line
//   CVM300_Data_valid  out  1       high during active pixels
//   CVM300_D           out  DATA_W  pixel value, 0 when not valid
//   frame_busy         out  1       high from accepted request to frame end
//   frame_count        out  16      completed frames, wraps at 0xFFFF
// -----------------------------------------------------------------------------
module cmv300_stream_emulator #(
  parameter int H_PIXELS    = 648,
  parameter int V_LINES     = 488,
  parameter int LINE_GAP    = 8,
  parameter int FRAME_DELAY = 16,
  parameter int DATA_W      = 8
) (
  input  logic              CVM300_CLK_IN,
  input  logic              CVM300_SYS_RES_N,
  input  logic              CVM300_FRAME_REQ,
  input  logic [1:0]        pattern_sel,
  output logic              CVM300_Line_valid,
  output logic              CVM300_Data_valid,
  output logic [DATA_W-1:0] CVM300_D,
  output logic              frame_busy,
  output logic [15:0]       frame_count
);

  // Each counter is wide enough for 0..PARAM-1, and always at least 1 bit.
  localparam int COL_W = (H_PIXELS    > 1) ? $clog2(H_PIXELS)    : 1;
  localparam int ROW_W = (V_LINES     > 1) ? $clog2(V_LINES)     : 1;
  localparam int GAP_W = (LINE_GAP    > 1) ? $clog2(LINE_GAP)    : 1;
  localparam int DLY_W = (FRAME_DELAY > 1) ? $clog2(FRAME_DELAY) : 1;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(H_PIXELS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(V_LINES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(LINE_GAP - 1);
  localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(FRAME_DELAY - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DELAY,
    S_LINE,
    S_GAP
  } state_e;

  state_e              state_q, state_d;
  logic                req_q;
  logic [1:0]          pat_q, pat_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic [DLY_W-1:0]    dly_q, dly_d;
  logic                valid_q, valid_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                busy_q, busy_d;
  logic [15:0]         frame_count_q, frame_count_d;

  logic                req_rise;
  logic [7:0]          col8;
  logic [7:0]          row8;
  logic [7:0]          pix8;

  // Only a fresh 0->1 transition counts. A level held high across frame end
  // does not start another frame.
  assign req_rise = CVM300_FRAME_REQ & ~req_q;

  // Patterns are defined on the low 8 bits of the column and row indices.
  assign col8 = 8'(col_q);
  assign row8 = 8'(row_q);

  always_comb begin
    pix8 = col8;
    case (pat_q)
      2'd0:    pix8 = col8;
      2'd1:    pix8 = row8;
      2'd2:    pix8 = col8 + row8;
      default: pix8 = (col_q[0] ^ row_q[0]) ? 8'hFF : 8'h00;
    endcase
  end

  // Next-state and registered-output logic.
  // NOTE: every signal gets its default first, so no path through the case
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d       = state_q;
    pat_d         = pat_q;
    col_d         = col_q;
    row_d         = row_q;
    gap_d         = gap_q;
    dly_d         = dly_q;
    valid_d       = 1'b0;
    data_d        = '0;
    busy_d        = busy_q;
    frame_count_d = frame_count_q;

    case (state_q)
      S_IDLE: begin
        if (req_rise) begin
          state_d = S_DELAY;
          pat_d   = pattern_sel;
          col_d   = '0;
          row_d   = '0;
          dly_d   = '0;
          busy_d  = 1'b1;
        end
      end

      S_DELAY: begin
        if (dly_q == DLY_LAST) begin
          state_d = S_LINE;
        end else begin
          dly_d = dly_q + DLY_W'(1);
        end
      end

      S_LINE: begin
        valid_d = 1'b1;
        data_d  = DATA_W'(pix8);
        if (col_q == COL_LAST) begin
          col_d = '0;
          if (row_q == ROW_LAST) begin
            // The last pixel goes out on the same edge that ends the frame.
            state_d       = S_IDLE;
            busy_d        = 1'b0;
            frame_count_d = frame_count_q + 16'd1;
          end else begin
            state_d = S_GAP;
            row_d   = row_q + ROW_W'(1);
            gap_d   = '0;
          end
        end else begin
          col_d = col_q + COL_W'(1);
        end
      end

      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = S_LINE;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments, so every register
  // samples the values from before the edge and evaluation order cannot matter.
  always_ff @(posedge CVM300_CLK_IN or negedge CVM300_SYS_RES_N) begin
    if (!CVM300_SYS_RES_N) begin
      state_q       <= S_IDLE;
      req_q         <= 1'b0;
      pat_q         <= 2'd0;
      col_q         <= '0;
      row_q         <= '0;
      gap_q         <= '0;
      dly_q         <= '0;
      valid_q       <= 1'b0;
      data_q        <= '0;
      busy_q        <= 1'b0;
      frame_count_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      req_q         <= CVM300_FRAME_REQ;
      pat_q         <= pat_d;
      col_q         <= col_d;
      row_q         <= row_d;
      gap_q         <= gap_d;
      dly_q         <= dly_d;
      valid_q       <= valid_d;
      data_q        <= data_d;
      busy_q        <= busy_d;
      frame_count_q <= frame_count_d;
    end
  end

  // Line and data valid are identical in every cycle, so one register drives both.
  assign CVM300_Line_valid = valid_q;
  assign CVM300_Data_valid = valid_q;
  assign CVM300_D          = data_q;
  assign frame_busy        = busy_q;
  assign frame_count       = frame_count_q;

endmodule

// File: tb/tb_cmv300_stream_emulator.sv
// -----------------------------------------------------------------------------
// tb_cmv300_stream_emulator
//
// Stimulus tasks drive FRAME_REQ and pattern_sel. Whenever a request should be
// accepted, the reference model schedules every pixel of the frame as a
// (cycle, value) pair in a queue, along with the frame's busy window and the
// frame count before and after the frame. A monitor samples the DUT on every
// falling edge and compares all outputs against that schedule.
// -----------------------------------------------------------------------------
module tb_cmv300_stream_emulator;

  localparam int H  = 4;
  localparam int V  = 3;
  localparam int G  = 2;
  localparam int FD = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic [1:0]  pat_sel = 2'd0;
  logic        line_valid;
  logic        data_valid;
  logic [7:0]  d_out;
  logic        busy;
  logic [15:0] fcount;

  cmv300_stream_emulator #(
    .H_PIXELS    (H),
    .V_LINES     (V),
    .LINE_GAP    (G),
    .FRAME_DELAY (FD),
    .DATA_W      (8)
  ) dut (
    .CVM300_CLK_IN     (clk),
    .CVM300_SYS_RES_N  (rst_n),
    .CVM300_FRAME_REQ  (req),
    .pattern_sel       (pat_sel),
    .CVM300_Line_valid (line_valid),
    .CVM300_Data_valid (data_valid),
    .CVM300_D          (d_out),
    .frame_busy        (busy),
    .frame_count       (fcount)
  );

  always #5 clk = ~clk;

  // cyc is the number of rising edges seen so far.
  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int         cyc;
    logic [7:0] data;
  } pix_t;

  pix_t        exp_q[$];
  int          cur_start  = 0;
  int          cur_end    = 0;
  logic [15:0] cnt_before = 16'd0;
  logic [15:0] cnt_after  = 16'd0;
  logic        req_prev   = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Pixel value straight from the pattern definitions.
  function automatic logic [7:0] model_pix(input int pat, input int c, input int r);
    case (pat)
      0:       return 8'(c % 256);
      1:       return 8'(r % 256);
      2:       return 8'((c + r) % 256);
      default: return (((c + r) % 2) == 1) ? 8'hFF : 8'h00;
    endcase
  endfunction

  // Schedule a frame that is accepted on rising edge e.
  task automatic model_accept(input int e, input int pat);
    pix_t p;
    for (int r = 0; r < V; r++) begin
      for (int c = 0; c < H; c++) begin
        p.cyc  = e + FD + 1 + r * (H + G) + c;
        p.data = model_pix(pat, c, r);
        exp_q.push_back(p);
      end
    end
    cur_start  = e;
    cur_end    = e + FD + V * H + (V - 1) * G;
    cnt_before = cnt_after;
    cnt_after  = cnt_after + 16'd1;
  endtask

  // Change FRAME_REQ and pattern_sel on a falling edge. The next rising edge
  // accepts the request only on a 0->1 change while the emulator is idle.
  task automatic drive(input logic v, input logic [1:0] pat);
    int e;
    @(negedge clk);
    e = cyc + 1;
    if (v && !req_prev && e > cur_end)
      model_accept(e, int'(pat));
    req      = v;
    pat_sel  = pat;
    req_prev = v;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Run until one cycle after the most recently scheduled frame has ended.
  task automatic wait_frame_done();
    while (cyc <= cur_end + 1) @(negedge clk);
  endtask

  // Pulse reset partway through a line and check that the outputs clear at once.
  task automatic mid_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_data_valid", 32'(data_valid), 32'd0);
    check("rst_line_valid", 32'(line_valid), 32'd0);
    check("rst_d",          32'(d_out),      32'd0);
    check("rst_busy",       32'(busy),       32'd0);
    check("rst_count",      32'(fcount),     32'd0);
    exp_q.delete();
    cur_start  = 0;
    cur_end    = 0;
    cnt_before = 16'd0;
    cnt_after  = 16'd0;
    wait_cycles(2);
    rst_n = 1'b1;
  endtask

  // Monitor: compares every output on every falling edge.
  always @(negedge clk) begin
    logic       exp_valid;
    logic [7:0] exp_d;
    logic       exp_busy;
    exp_valid = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
    exp_d     = exp_valid ? exp_q[0].data : 8'h00;
    exp_busy  = rst_n && (cyc >= cur_start) && (cyc < cur_end);
    check("data_valid", 32'(data_valid), 32'(exp_valid));
    check("line_valid", 32'(line_valid), 32'(exp_valid));
    check("pixel_d",    32'(d_out),      32'(exp_d));
    check("frame_busy", 32'(busy),       32'(exp_busy));
    check("frame_count", 32'(fcount), 32'((cyc >= cur_end) ? cnt_after : cnt_before));
    if (exp_valid) void'(exp_q.pop_front());
  end

  initial begin
    rst_n = 1'b0;
    wait_cycles(3);
    rst_n = 1'b1;

    // One request per pattern. On the checker frame, pattern_sel changes
    // mid-frame and must not take effect.
    drive(1'b1, 2'd0); drive(1'b0, 2'd0); wait_frame_done();
    drive(1'b1, 2'd2); drive(1'b0, 2'd2); wait_frame_done();
    drive(1'b1, 2'd3); drive(1'b0, 2'd0); wait_frame_done();
    drive(1'b1, 2'd1); drive(1'b0, 2'd1); wait_frame_done();

    // A second rising edge during line 1 is ignored.
    drive(1'b1, 2'd0); drive(1'b0, 2'd0);
    wait_cycles(8);
    drive(1'b1, 2'd2); drive(1'b0, 2'd1);
    wait_frame_done();

    // A request held high through frame end does not retrigger. A fresh edge does.
    drive(1'b1, 2'd3);
    wait_cycles(30);
    drive(1'b0, 2'd3); drive(1'b1, 2'd0); drive(1'b0, 2'd0);
    wait_frame_done();

    // Reset during line 1, then run a complete frame after release.
    drive(1'b1, 2'd2); drive(1'b0, 2'd2);
    wait_cycles(9);
    mid_reset();
    drive(1'b1, 2'd0); drive(1'b0, 2'd0); wait_frame_done();

    // Preload the frame count at 0xFFFF. The next frame wraps it to 0x0000.
    @(negedge clk);
    #2;
    force dut.frame_count_q = 16'hFFFF;
    cnt_before = 16'hFFFF;
    cnt_after  = 16'hFFFF;
    #1;
    release dut.frame_count_q;
    drive(1'b1, 2'd1); drive(1'b0, 2'd1); wait_frame_done();

    // Random frames with random request toggling, some of it while busy.
    for (int i = 0; i < 25; i++) begin
      wait_cycles($urandom_range(0, 5));
      drive(1'b1, 2'($urandom_range(0, 3)));
      for (int k = 0; k < int'($urandom_range(1, 25)); k++)
        drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
      drive(1'b0, 2'($urandom_range(0, 3)));
      wait_frame_done();
    end

    wait_cycles(3);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
